mc_control_fsm: RTL and testbench

Multi-cycle main control unit for the 16-bit MIPS datapath. It decodes the opcode, sequences fetch/decode/execute/memory/writeback, and issues the 3-bit ALU operation code to the ALU block. It consumes the ALU `zero` flag to resolve branches. It also runs a req/ready handshake with the unified instruction/data memory.

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_mem_wait_timer.sv | 34 +++
 rtl/mc_control_fsm.sv | 159 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and its ALU control.
// Combinational constants/helpers only; no latency.
// No flow control of its own.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_R   = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;
  localparam logic [2:0] ALUOP_BR  = 3'b100;
  localparam logic [2:0] ALUOP_SLT = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALUOP_AND;
      OP_ORI:  imm_alu_op = ALUOP_OR;
      OP_SLTI: imm_alu_op = ALUOP_SLT;
      default: imm_alu_op = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts memory wait cycles and flags a timeout on the TIMEOUT-th wait cycle.
// expire is combinational from the count and ready; the count updates next edge.
// No backpressure; ready completing in the expiry cycle suppresses the timeout.
module mc_mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam int              LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LAST  = LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q;

  assign expire = (TIMEOUT != 0) && active && !ready && (cnt_q == LAST);

  // Any cycle that is not a continuing wait leaves the count at zero, which
  // gives the clear-on-entry behaviour without tracking state transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (active && !ready && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control for the 16-bit MIPS datapath (Moore FSM).
// 3-5 cycles per instruction with zero-wait memory; each wait cycle adds one.
// Stalls on mem_ready in FETCH/MEM_RD/MEM_WR; times out to FETCH with bus_err.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       bus_err
);

  state_t state_q, state_d;
  logic   abort_q;
  logic   bne_q;
  logic   waiting;
  logic   timeout;

  // The cycle after a timeout is a dead FETCH cycle with mem_req low so the
  // memory sees the aborted request drop before a fresh one is issued.
  assign waiting = ((state_q == S_FETCH) && !abort_q) ||
                   (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mc_mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (waiting),
    .ready  (mem_ready),
    .expire (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      abort_q <= 1'b0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= timeout;
      if (state_q == S_DECODE) begin
        bne_q <= (opcode == OP_BNE);
      end
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    bus_err    = timeout;

    case (state_q)
      S_FETCH: begin
        mem_req   = !abort_q;
        alu_src_b = SRCB_TWO;
        if (!abort_q && mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_SHIMM;
        case (opcode)
          OP_R:                             state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          default:                          illegal_op = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_R;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op(opcode);
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FETCH;
        else              state_d = S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        state_d = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_BR;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = bne_q ? !zero : zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control word queued
// at stimulus time, popped and compared against the DUT outputs mid-cycle.
module tb_mc_control_fsm;

  typedef enum int {
    T_FETCH, T_ABORT, T_DECODE, T_EXEC_R, T_WB_R, T_EXEC_I, T_WB_I,
    T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR, T_BRANCH, T_JUMP
  } tst_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic       bus_err;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal_op, bus_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  mc_control_fsm #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .bus_err    (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  // Control word each state must present, written straight from the state table.
  function automatic out_t model(input tst_e s, input logic rdy, input logic z,
                                 input logic [3:0] op, input logic bus);
    out_t o = '0;
    case (s)
      T_FETCH:    begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      T_ABORT:    o.alu_src_b = 2'b01;
      T_DECODE:   begin o.alu_src_b = 2'b11; o.illegal_op = (op >= 4'b1010); end
      T_EXEC_R:   begin o.alu_src_a = 1; o.alu_op = 3'b001; end
      T_WB_R:     begin o.reg_write = 1; o.reg_dst = 1; end
      T_EXEC_I: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10;
        case (op)
          4'b0010: o.alu_op = 3'b010;
          4'b0011: o.alu_op = 3'b011;
          4'b0100: o.alu_op = 3'b101;
          default: o.alu_op = 3'b000;
        endcase
      end
      T_WB_I:     o.reg_write = 1;
      T_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      T_MEM_RD:   begin o.mem_req = 1; o.i_or_d = 1; end
      T_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
      T_MEM_WR:   begin o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; end
      T_BRANCH: begin
        o.alu_src_a = 1; o.alu_op = 3'b100; o.pc_src = 2'b01;
        o.pc_write = (op == 4'b1000) ? !z : z;
      end
      T_JUMP:     begin o.pc_write = 1; o.pc_src = 2'b10; end
      default:    o = '0;
    endcase
    o.bus_err = bus;
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o = '{mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err};
    return o;
  endfunction

  // One clock cycle: drive, queue the expectation, compare at the falling edge.
  task automatic cyc(input tst_e s, input logic rdy, input logic bus);
    exp_t e;
    mem_ready = rdy;
    e.tag = s.name();
    e.v   = model(s, rdy, zero, opcode, bus);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, 32'(observed()), 32'(e.v));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    opcode = op;
    zero   = z;
    repeat (fw) cyc(T_FETCH, 1'b0, 1'b0);
    cyc(T_FETCH, 1'b1, 1'b0);
    cyc(T_DECODE, 1'b1, 1'b0);
    case (op)
      4'd0: begin cyc(T_EXEC_R, 1'b1, 1'b0); cyc(T_WB_R, 1'b1, 1'b0); end
      4'd1, 4'd2, 4'd3, 4'd4: begin cyc(T_EXEC_I, 1'b1, 1'b0); cyc(T_WB_I, 1'b1, 1'b0); end
      4'd5: begin
        cyc(T_MEM_ADDR, 1'b1, 1'b0);
        repeat (mw) cyc(T_MEM_RD, 1'b0, 1'b0);
        cyc(T_MEM_RD, 1'b1, 1'b0);
        cyc(T_MEM_WB, 1'b1, 1'b0);
      end
      4'd6: begin
        cyc(T_MEM_ADDR, 1'b1, 1'b0);
        repeat (mw) cyc(T_MEM_WR, 1'b0, 1'b0);
        cyc(T_MEM_WR, 1'b1, 1'b0);
      end
      4'd7, 4'd8: cyc(T_BRANCH, 1'b1, 1'b0);
      4'd9:       cyc(T_JUMP, 1'b1, 1'b0);
      default: ;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(T_FETCH, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_instr(4'b0000, 0, 0, 1'b0);
    run_instr(4'b0001, 1, 0, 1'b0);
    run_instr(4'b0010, 0, 0, 1'b1);
    run_instr(4'b0011, 2, 0, 1'b0);
    run_instr(4'b0100, 0, 0, 1'b0);
    run_instr(4'b0101, 0, 2, 1'b0);
    run_instr(4'b0101, 0, 0, 1'b1);
    run_instr(4'b0110, 0, 1, 1'b0);
    run_instr(4'b0110, 3, 0, 1'b1);
    run_instr(4'b0111, 0, 0, 1'b1);
    run_instr(4'b0111, 0, 0, 1'b0);
    run_instr(4'b1000, 0, 0, 1'b0);
    run_instr(4'b1000, 1, 0, 1'b1);
    run_instr(4'b1001, 0, 0, 1'b0);
    run_instr(4'b1100, 0, 0, 1'b0);
    run_instr(4'b1010, 0, 0, 1'b1);
    run_instr(4'b1111, 0, 0, 1'b0);

    // Fetch timeout, then a second full wait ending with ready on the last cycle.
    opcode = 4'b0000;
    repeat (14) cyc(T_FETCH, 1'b0, 1'b0);
    cyc(T_FETCH, 1'b0, 1'b1);
    cyc(T_ABORT, 1'b1, 1'b0);
    repeat (14) cyc(T_FETCH, 1'b0, 1'b0);
    cyc(T_FETCH, 1'b1, 1'b0);
    cyc(T_DECODE, 1'b1, 1'b0);
    cyc(T_EXEC_R, 1'b1, 1'b0);
    cyc(T_WB_R, 1'b1, 1'b0);

    // Read-side timeout.
    opcode = 4'b0101;
    cyc(T_FETCH, 1'b1, 1'b0);
    cyc(T_DECODE, 1'b1, 1'b0);
    cyc(T_MEM_ADDR, 1'b1, 1'b0);
    repeat (14) cyc(T_MEM_RD, 1'b0, 1'b0);
    cyc(T_MEM_RD, 1'b0, 1'b1);
    cyc(T_ABORT, 1'b0, 1'b0);
    run_instr(4'b0100, 0, 0, 1'b0);

    // Reset while a store is stalled.
    opcode = 4'b0110;
    cyc(T_FETCH, 1'b1, 1'b0);
    cyc(T_DECODE, 1'b1, 1'b0);
    cyc(T_MEM_ADDR, 1'b1, 1'b0);
    cyc(T_MEM_WR, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(T_MEM_WR, 1'b0, 1'b0);
    cyc(T_FETCH, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_instr(4'b0000, 0, 0, 1'b0);
    repeat (14) cyc(T_FETCH, 1'b0, 1'b0);
    cyc(T_FETCH, 1'b1, 1'b0);
    cyc(T_DECODE, 1'b1, 1'b0);
    cyc(T_EXEC_R, 1'b1, 1'b0);
    cyc(T_WB_R, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
